// File: rtl/pc_gen.sv
// pc_gen: program-counter register and next-PC generator for the single-cycle core.
// Issues the fetch address and PC+4 link value, handshakes fetches with imem,
// counts retired instructions and halts on a JAL-to-self for end-of-test.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect traps to TRAP_VECTOR and sets a sticky flag. When it is undefined,
// redirect targets are word-aligned and the flag reads 0.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_gen_out,
   input  logic [XLEN-1:0] target_addr,
   input  logic [6:0]      opcode,
   input  logic            stall,
   input  logic            imem_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            imem_req,
   output logic [63:0]     instret,
   output logic            halted,
   output logic            misalign_flag
);

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            advance;
   logic            misalign;
   logic            halt_hit;
   logic [XLEN-1:0] redirect_addr;
   logic [XLEN-1:0] next_pc;

   assign pc_plus4 = pc + XLEN'(4);
   assign advance  = (state == RUN) & imem_ready & ~stall;

   // Next-PC selection: sequential PC+4 or the redirect target (JALR clears bit 0)
   always_comb begin
      redirect_addr = target_addr;
      if (opcode == OP_JALR) begin
         redirect_addr[0] = 1'b0;
      end
`ifdef PC_MISALIGN_TRAP_EN
      misalign = pc_gen_out & (redirect_addr[1:0] != 2'b00);
      next_pc  = pc_gen_out ? redirect_addr : pc_plus4;
`else
      misalign = 1'b0;
      next_pc  = pc_gen_out ? (redirect_addr & ~XLEN'(3)) : pc_plus4;
`endif
      halt_hit = advance & pc_gen_out & (opcode == OP_JAL) & ~misalign & (next_pc == pc);
   end

   // Control FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Control FSM next state and fetch/halt outputs
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      halted    = 1'b0;
      case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            imem_req = 1'b1;
            if (halt_hit) begin
               state_nxt = HALT;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   // PC register and retired-instruction counter, both move only on an advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_VECTOR;
         instret <= 64'd0;
      end else if (advance) begin
         pc      <= misalign ? TRAP_VECTOR : next_pc;
         instret <= instret + 64'd1;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   // Sticky misaligned-redirect flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_flag <= 1'b0;
      end else if (advance & misalign) begin
         misalign_flag <= 1'b1;
      end
   end
`else
   assign misalign_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with a behavioural reference model
// and a per-cycle compare, plus literal expectations at key points.
module tb_pc_gen;

   localparam logic [6:0]  OP_JAL  = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111;
   localparam logic [6:0]  OP_BR   = 7'b1100011;
   localparam logic [31:0] TRAPV   = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        pc_gen_out;
   logic [31:0] target_addr;
   logic [6:0]  opcode;
   logic        stall;
   logic        imem_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        imem_req;
   logic [63:0] instret;
   logic        halted;
   logic        misalign_flag;

   int checks   = 0;
   int failures = 0;

   pc_gen dut (
      .clk          (clk),
      .rst          (rst),
      .pc_gen_out   (pc_gen_out),
      .target_addr  (target_addr),
      .opcode       (opcode),
      .stall        (stall),
      .imem_ready   (imem_ready),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .imem_req     (imem_req),
      .instret      (instret),
      .halted       (halted),
      .misalign_flag(misalign_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what the core's architectural state must be
   logic        m_boot;
   logic        m_halt;
   logic        m_flag;
   logic [31:0] m_pc;
   logic [63:0] m_ret;
   logic [31:0] m_tgt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_boot <= 1'b1;
         m_halt <= 1'b0;
         m_flag <= 1'b0;
         m_pc   <= 32'h0;
         m_ret  <= 64'd0;
      end else if (m_boot) begin
         m_boot <= 1'b0;
      end else if (!m_halt && imem_ready && !stall) begin
         m_ret <= m_ret + 64'd1;
         if (!pc_gen_out) begin
            m_pc <= m_pc + 32'd4;
         end else begin
            m_tgt = (opcode == OP_JALR) ? {target_addr[31:1], 1'b0} : target_addr;
`ifdef PC_MISALIGN_TRAP_EN
            if (m_tgt % 4 != 0) begin
               m_pc   <= TRAPV;
               m_flag <= 1'b1;
            end else begin
               m_pc <= m_tgt;
               if (opcode == OP_JAL && m_tgt == m_pc) m_halt <= 1'b1;
            end
`else
            m_tgt = m_tgt - (m_tgt % 4);
            m_pc <= m_tgt;
            if (opcode == OP_JAL && m_tgt == m_pc) m_halt <= 1'b1;
`endif
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      chk("cmp_pc", {32'h0, pc}, {32'h0, m_pc});
      chk("cmp_pc_plus4", {32'h0, pc_plus4}, {32'h0, m_pc + 32'd4});
      chk("cmp_imem_req", {63'h0, imem_req}, {63'h0, (!m_boot && !m_halt)});
      chk("cmp_instret", instret, m_ret);
      chk("cmp_halted", {63'h0, halted}, {63'h0, m_halt});
      chk("cmp_misalign_flag", {63'h0, misalign_flag}, {63'h0, m_flag});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic redirect(input logic [6:0] op, input logic [31:0] tgt);
      pc_gen_out  = 1'b1;
      opcode      = op;
      target_addr = tgt;
   endtask

   initial begin
      rst         = 1'b0;
      pc_gen_out  = 1'b0;
      target_addr = 32'h0;
      opcode      = 7'h13;
      stall       = 1'b0;
      imem_ready  = 1'b1;
      #1 rst = 1'b1;
      step();
      step();
      chk("rst_pc", {32'h0, pc}, 64'h0);
      chk("rst_req", {63'h0, imem_req}, 64'h0);
      chk("rst_instret", instret, 64'h0);
      chk("rst_halted", {63'h0, halted}, 64'h0);
      chk("rst_flag", {63'h0, misalign_flag}, 64'h0);

      // Reset release: one bubble, then sequential fetch
      rst = 1'b0;
      #1;
      chk("boot_pc", {32'h0, pc}, 64'h0);
      chk("boot_req", {63'h0, imem_req}, 64'h0);
      step();
      chk("run_pc0", {32'h0, pc}, 64'h0);
      chk("run_req", {63'h0, imem_req}, 64'h1);
      step();
      chk("seq_pc4", {32'h0, pc}, 64'h4);
      step();
      chk("seq_pc8", {32'h0, pc}, 64'h8);
      step();
      chk("seq_pc12", {32'h0, pc}, 64'hC);
      chk("seq_instret3", instret, 64'd3);

      // Taken branch redirects
      redirect(OP_BR, 32'h40);
      step();
      chk("br_pc40", {32'h0, pc}, 64'h40);
      redirect(OP_BR, 32'h80);
      step();
      chk("br_pc80", {32'h0, pc}, 64'h80);
      chk("br_plus4", {32'h0, pc_plus4}, 64'h84);

      // JALR with stall first: stall wins, then bit 0 cleared
      redirect(OP_JALR, 32'h201);
      stall = 1'b1;
      step();
      chk("stall_pc", {32'h0, pc}, 64'h80);
      chk("stall_instret", instret, 64'd5);
      stall = 1'b0;
      step();
      chk("jalr_pc", {32'h0, pc}, 64'h200);
      chk("jalr_instret", instret, 64'd6);

      // imem not ready: hold
      pc_gen_out = 1'b0;
      imem_ready = 1'b0;
      step();
      chk("nordy_pc", {32'h0, pc}, 64'h200);
      imem_ready = 1'b1;

      // Address wrap
      redirect(OP_BR, 32'hFFFF_FFFC);
      step();
      chk("wrap_plus4", {32'h0, pc_plus4}, 64'h0);
      pc_gen_out = 1'b0;
      step();
      chk("wrap_pc", {32'h0, pc}, 64'h0);

      // Async reset mid-run at pc 0x3C
      redirect(OP_BR, 32'h38);
      step();
      pc_gen_out = 1'b0;
      step();
      chk("pre_rst_pc", {32'h0, pc}, 64'h3C);
      rst = 1'b1;
      #1;
      chk("async_rst_pc", {32'h0, pc}, 64'h0);
      chk("async_rst_instret", instret, 64'h0);
      #1 rst = 1'b0;
      step();

      // JAL to self halts
      redirect(OP_BR, 32'h100);
      step();
      redirect(OP_JAL, 32'h100);
      step();
      chk("halt_flag", {63'h0, halted}, 64'h1);
      chk("halt_req", {63'h0, imem_req}, 64'h0);
      chk("halt_instret", instret, 64'd2);
      redirect(OP_BR, 32'h400);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("halt_hold_pc", {32'h0, pc}, 64'h100);
      end

      // Misaligned JAL target
      pc_gen_out = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      redirect(OP_BR, 32'h100);
      step();
      redirect(OP_JAL, 32'h102);
      step();
      chk("mis_pc", {32'h0, pc}, 64'h100);
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_flag", {63'h0, misalign_flag}, 64'h1);
      chk("mis_halted", {63'h0, halted}, 64'h0);
`else
      chk("mis_flag", {63'h0, misalign_flag}, 64'h0);
      chk("mis_halted", {63'h0, halted}, 64'h1);
`endif
      pc_gen_out = 1'b0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
